// File: rtl/load_store_unit_if.sv
// load_store_unit_if: datapath request/response and data-memory port bundle of the load/store unit
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_sel;
   logic [31:0] mem_rd_data;
   // datapath plus memory, as seen from outside the unit
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_data, mem_wr_sel
   );
   // the load/store unit itself
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_data, mem_wr_sel
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: word-aligned data-memory initiator, splits misaligned accesses (MISALIGNED_TRAP_EN traps them instead)
module load_store_unit (
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
   state_t      state_q, state_d;
   logic        we_q, we_d, uns_q, uns_d, valid_q, valid_d, err_q, err_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, lo_q, lo_d, rdata_q, rdata_d;
   logic [31:0] base, maddr, mwdata;
   logic [3:0]  msel;
   logic [2:0]  nbytes;
   logic        spans;
   logic [7:0]  bmask8;
   logic [63:0] wdata64;
   assign nbytes  = size_q == 2'd0 ? 3'd1 : size_q == 2'd1 ? 3'd2 : 3'd4;
   assign spans   = {2'b00, addr_q[1:0]} + {1'b0, nbytes} > 4'd4;
   assign bmask8  = ((8'd1 << nbytes) - 8'd1) << addr_q[1:0];
   assign wdata64 = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
   assign base    = {addr_q[31:2], 2'b00};
`ifdef MISALIGNED_TRAP_EN
   logic mis;
   assign mis = bus.req_size == 2'd1 ? bus.req_addr[0] : bus.req_size != 2'd0 && bus.req_addr[1:0] != 2'd0;
`endif
   // shift the two captured words down to the access offset, then extend to 32 bits
   function automatic logic [31:0] ext(input logic [63:0] d, input logic [1:0] off, input logic [1:0] sz, input logic u);
      logic [31:0] s;
      s = 32'(d >> {off, 3'b000});
      return sz == 2'd0 ? {{24{s[7] & ~u}}, s[7:0]} : sz == 2'd1 ? {{16{s[15] & ~u}}, s[15:0]} : s;
   endfunction
   // sequencing, memory beat drive and response formation
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      uns_d   = uns_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      lo_d    = lo_q;
      rdata_d = rdata_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      maddr   = 32'h0;
      mwdata  = 32'h0;
      msel    = 4'h0;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            we_d    = bus.req_we;
            uns_d   = bus.req_unsigned;
            size_d  = bus.req_size;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            state_d = BEAT0;
`ifdef MISALIGNED_TRAP_EN
            if (mis) begin
               state_d = RESP;
               valid_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = 32'h0;
            end
`endif
         end
         BEAT0: begin
            maddr = base;
            mwdata = we_q ? wdata64[31:0] : 32'h0;
            msel = we_q ? bmask8[3:0] : 4'h0;
            lo_d = bus.mem_rd_data;
            state_d = spans ? BEAT1 : RESP;
            valid_d = !spans;
            if (!spans) rdata_d = we_q ? 32'h0 : ext({32'h0, bus.mem_rd_data}, addr_q[1:0], size_q, uns_q);
         end
         BEAT1: begin
            maddr = base + 32'd4;
            mwdata = we_q ? wdata64[63:32] : 32'h0;
            msel = we_q ? bmask8[7:4] : 4'h0;
            state_d = RESP;
            valid_d = 1'b1;
            rdata_d = we_q ? 32'h0 : ext({bus.mem_rd_data, lo_q}, addr_q[1:0], size_q, uns_q);
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered response; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         lo_q    <= 32'h0;
         rdata_q <= 32'h0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end
   assign bus.req_ready   = state_q == IDLE;
   assign bus.resp_valid  = valid_q;
   assign bus.resp_rdata  = rdata_q;
   assign bus.resp_err    = err_q;
   assign bus.mem_addr    = maddr;
   assign bus.mem_wr_data = mwdata;
   assign bus.mem_wr_sel  = msel;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: byte-level memory model and per-cycle expected-beat queue checking the load/store unit
module tb_load_store_unit;
   typedef struct {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wd;
      logic        v;
      logic [31:0] rd;
      logic        err;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   load_store_unit_if bus();
   load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   logic [31:0] dmem [256] = '{default: 32'h0};
   logic [7:0]  ref_mem [1024] = '{default: 8'h0};
   exp_t        expq [$];
   int          total = 0, passed = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   time         t_acc, t_resp;
   always #5 clk = ~clk;
   assign bus.mem_rd_data = dmem[bus.mem_addr[9:2]];
   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (bus.mem_wr_sel[i]) dmem[bus.mem_addr[9:2]][8*i +: 8] <= bus.mem_wr_data[8*i +: 8];
   task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s got %h expected %h at %0t", n, got, want, $time);
   endtask
   function automatic logic [31:0] lm(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction
   // expected memory beats and response for one accepted request, from the byte-level view
   task automatic model(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] wd);
      int nb, k, lane;
      exp_t b [2];
      exp_t r;
      logic [31:0] v, ba;
      nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      r = '{addr: 32'h0, sel: 4'h0, wd: 32'h0, v: 1'b1, rd: 32'h0, err: 1'b0};
`ifdef MISALIGNED_TRAP_EN
      if (int'(a[1:0]) % nb != 0) begin
         r.err = 1'b1;
         expq.push_back(r);
         return;
      end
`endif
      b[0] = '{addr: 32'h0, sel: 4'h0, wd: 32'h0, v: 1'b0, rd: 32'h0, err: 1'b0};
      b[1] = b[0];
      v = 32'h0;
      for (int i = 0; i < nb; i++) begin
         ba = a + 32'(i);
         k = (int'(a[1:0]) + i) / 4;
         lane = int'(ba[1:0]);
         b[k].addr = {ba[31:2], 2'b00};
         if (we) begin
            b[k].sel[lane] = 1'b1;
            b[k].wd[8*lane +: 8] = wd[8*i +: 8];
            ref_mem[ba[9:0]] = wd[8*i +: 8];
         end else v[8*i +: 8] = ref_mem[ba[9:0]];
      end
      if (nb < 4 && !u && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
      r.rd = we ? 32'h0 : v;
      expq.push_back(b[0]);
      if (int'(a[1:0]) + nb > 4) expq.push_back(b[1]);
      expq.push_back(r);
   endtask
   // every cycle: outputs must match the queued expectation, or the idle values when nothing is queued
   always @(negedge clk) begin : cmp
      exp_t x;
      logic idle;
      if (rst_n) begin
         idle = expq.size() == 0;
         x = idle ? '{addr: 32'h0, sel: 4'h0, wd: 32'h0, v: 1'b0, rd: 32'h0, err: 1'b0} : expq.pop_front();
         check("req_ready", {31'h0, bus.req_ready}, {31'h0, idle});
         check("mem_addr", bus.mem_addr, x.addr);
         check("mem_wr_sel", {28'h0, bus.mem_wr_sel}, {28'h0, x.sel});
         if (x.sel != 4'h0) check("mem_wr_data", bus.mem_wr_data & lm(x.sel), x.wd & lm(x.sel));
         check("resp_valid", {31'h0, bus.resp_valid}, {31'h0, x.v});
         if (x.v) begin
            check("resp_rdata", bus.resp_rdata, x.rd);
            check("resp_err", {31'h0, bus.resp_err}, {31'h0, x.err});
            last_rdata = bus.resp_rdata;
            last_err = bus.resp_err;
            t_resp = $time;
         end
      end
   end
   task automatic drain();
      int n = 0;
      while (expq.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      if (expq.size() != 0) begin
         check("drain_timeout", expq.size(), 0);
         expq.delete();
      end
   endtask
   task automatic issue(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] wd);
      drain();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_size = sz;
      bus.req_unsigned = u;
      bus.req_addr = a;
      bus.req_wdata = wd;
      @(posedge clk);
      t_acc = $time;
      model(we, sz, u, a, wd);
      #1 bus.req_valid = 1'b0;
   endtask
   task automatic ld(input string n, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] want);
      issue(1'b0, sz, u, a, $urandom);
      drain();
      check(n, last_rdata, want);
   endtask
   function automatic int lat();
      return int'((t_resp - t_acc + 5) / 10);
   endfunction
   initial begin
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0;
      #1;
      check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_err", {31'h0, bus.resp_err}, 32'h0);
      check("rst_addr", bus.mem_addr, 32'h0);
      check("rst_wdata", bus.mem_wr_data, 32'h0);
      check("rst_sel", {28'h0, bus.mem_wr_sel}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      ld("lw_100", 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      check("lw_latency", lat(), 2);
      issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF7F01);
      ld("lb_203", 2'd0, 1'b0, 32'h203, 32'hFFFFFF80);
      ld("lbu_203", 2'd0, 1'b1, 32'h203, 32'h00000080);
      ld("lb_200", 2'd0, 1'b0, 32'h200, 32'h00000001);
      ld("lh_202", 2'd1, 1'b0, 32'h202, 32'hFFFF80FF);
`ifdef MISALIGNED_TRAP_EN
      issue(1'b1, 2'd2, 1'b0, 32'h401, 32'h12345678);
      drain();
      check("trap_err", {31'h0, last_err}, 32'h1);
      check("trap_latency", lat(), 1);
`else
      issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h44332211);
      issue(1'b1, 2'd2, 1'b0, 32'h304, 32'h88776655);
      ld("lw_302", 2'd2, 1'b0, 32'h302, 32'h66554433);
      check("split_latency", lat(), 3);
      issue(1'b1, 2'd2, 1'b0, 32'h403, 32'hAABBCCDD);
      ld("lw_403", 2'd2, 1'b0, 32'h403, 32'hAABBCCDD);
      ld("lbu_403", 2'd0, 1'b1, 32'h403, 32'h000000DD);
      ld("lw_404", 2'd2, 1'b0, 32'h404, 32'h00AABBCC);
      issue(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h9A000000);
      issue(1'b1, 2'd2, 1'b0, 32'h00000000, 32'h000000F1);
      ld("lh_wrap", 2'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFF19A);
      ld("lhu_wrap", 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0000F19A);
`endif
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      end
      drain();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.req_size = 2'd2;
      bus.req_addr = 32'h200;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      check("mid_addr", bus.mem_addr, 32'h200);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sel", {28'h0, bus.mem_wr_sel}, 32'h0);
      check("mid_rst_addr", bus.mem_addr, 32'h0);
      check("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
      check("mid_rst_valid", {31'h0, bus.resp_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 20; i++) issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      drain();
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1);
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory port: accepts load/store requests from the datapath and drives the memory's addr/wr_data/wr_sel.
- Captures the combinational rd_data and returns sign- or zero-extended load data.
- Always presents word-aligned addresses, so it works with word-organised memories and memory-mapped peripherals.
- A misaligned access that spans two words is split into two memory beats.

Parameters:
- None. Widths are fixed by the rv32i package: word_t is 32 bits, byte_sel_t is 4 bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  datapath presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  load zero-extends (lbu/lhu); ignored for word and stores.
- req_addr  in  32  byte address, any alignment.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned error; only meaningful with MISALIGNED_TRAP_EN, else tied 0.
- mem_addr  out  32  word-aligned address to memory; bits [1:0] always 0.
- mem_wr_data  out  32  lane-aligned write data.
- mem_wr_sel  out  4  byte write enables.
- mem_rd_data  in  32  combinational read data from memory.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wr_data=0, mem_wr_sel=0.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: on req_valid && req_ready, register we/size/unsigned/addr/wdata, go to BEAT0. With req_valid low, stay in IDLE.
- Size and offset: nbytes = 1/2/4 from size; off = addr[1:0]; spans = (off + nbytes) > 4.
- Lane shifting: bmask8 = ((1<<nbytes)-1) << off, 8 bits wide. wdata64 = {32'b0, wdata} << (8*off).
- BEAT0:
  - mem_addr = {addr[31:2], 2'b00}.
  - Store: mem_wr_data = wdata64[31:0], mem_wr_sel = bmask8[3:0].
  - Load: mem_wr_sel = 0; capture mem_rd_data into lo at end of cycle.
  - Next state: BEAT1 if spans, else RESP.
- BEAT1:
  - mem_addr = {addr[31:2], 2'b00} + 4, mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - Store: mem_wr_data = wdata64[63:32], mem_wr_sel = bmask8[7:4].
  - Load: capture mem_rd_data into hi.
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - Loads: resp_rdata = ({hi, lo} >> 8*off), truncated to nbytes, then sign- or zero-extended. hi is treated as 0 when not split.
  - Stores: resp_rdata = 0.
  - Next state: IDLE.
- Latency, request accepted at cycle T:
  - Non-spanning access: memory beat at T+1, resp_valid at T+2.
  - Spanning access: beats at T+1 and T+2, resp_valid at T+3.
  - Back-to-back requests: next accept at the resp cycle + 1, i.e. a minimum 3-cycle issue interval.
- Outputs outside BEAT0/BEAT1: mem_wr_sel = 0 and mem_addr = 0. Memory is never written outside a beat.
- Response outputs are registered. resp_rdata holds its value until the next RESP.
- Reset mid-operation: immediately (asynchronously) return to IDLE and force mem_wr_sel = 0. No resp_valid is produced. A partially completed split store may leave beat0 bytes written; this is accepted.

Optional Feature:
- Macro: MISALIGNED_TRAP_EN.
- Defined:
  - A request with off not a multiple of nbytes (half at odd address, word at off≠0) performs no memory beat.
  - IDLE goes directly to RESP with resp_err=1 and resp_rdata=0.
  - Aligned accesses behave as normal with resp_err=0.
  - BEAT1 is unreachable and may be omitted.
- Undefined: misaligned accesses are split as described above; resp_err is constant 0.

Test Plan:
- Aligned store then load: store word 0xDEADBEEF at 0x100 → one beat, mem_addr=0x100, wr_sel=1111. Then lw 0x100 → resp_rdata=0xDEADBEEF at T+2.
- Byte load sign/zero: memory word 0x80FF7F01 at 0x200. lb 0x203 → 0xFFFFFF80. lbu 0x203 → 0x00000080. lb 0x200 → 0x00000001.
- Split load: words 0x44332211 at 0x300 and 0x88776655 at 0x304. lw 0x302 → two beats (0x300, 0x304), resp_rdata=0x66554433 at T+3.
- Split store: sw 0xAABBCCDD at 0x403.
  - Beat0: addr 0x400, wr_sel=1000, wr_data[31:24]=0xDD.
  - Beat1: addr 0x404, wr_sel=0111, wr_data[23:0]=0xAABBCC.
- Address wrap: lh at 0xFFFFFFFF → beats at 0xFFFFFFFC then 0x00000000, correct extended half returned.
- Reset during BEAT0 of a load: assert rst_n low → mem_wr_sel=0 immediately, no resp_valid. req_ready=1 after release. With MISALIGNED_TRAP_EN also run: sw at 0x401 → no write beat, resp_err=1 at T+1.
